// File: rtl/cv32e40s_instr_obi_arbiter.sv
// cv32e40s_instr_obi_arbiter
//
// Shares the instruction-side OBI transaction channel between two requesters.
// Requester 0 is the prefetcher and requester 1 is an auxiliary fetch source.
// Responses are routed back to the requester that issued the transaction.
// The number of accepted-but-unanswered transactions is capped. Responses to
// transactions killed by a flush are swallowed.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid_i     per-requester request valid
//   req_ready_o     per-requester accept
//   req_i           per-requester request payload
//   resp_valid_o    per-requester response valid (one-hot or zero)
//   resp_o          shared response payload (resp_i passed through)
//   trans_valid_o   request valid towards the OBI adapter
//   trans_ready_i   OBI adapter ready
//   trans_o         selected request payload
//   resp_valid_i    response valid from the OBI adapter
//   resp_i          response payload from the OBI adapter
//   kill_i          flush: discard in-flight responses, block new requests
//   idle_o          no transactions outstanding

package cv32e40s_instr_obi_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } obi_inst_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } obi_inst_resp_t;

endpackage

module cv32e40s_instr_obi_arbiter
  import cv32e40s_instr_obi_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  obi_inst_req_t [1:0]  req_i,
  output logic [1:0]           resp_valid_o,
  output obi_inst_resp_t       resp_o,
  output logic                 trans_valid_o,
  input  logic                 trans_ready_i,
  output obi_inst_req_t        trans_o,
  input  logic                 resp_valid_i,
  input  obi_inst_resp_t       resp_i,
  input  logic                 kill_i,
  output logic                 idle_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  logic [CW-1:0] cnt_q;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_q;
  logic          prio_q;
  logic          lock_q;
  logic          lock_id_q;
  logic          fifo_id_q      [MAX_OUTSTANDING];
  logic          fifo_discard_q [MAX_OUTSTANDING];

  logic sel;
  logic can_issue;
  logic push;
  logic pop;
  logic stall;
  logic head_id;
  logic head_discard;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Requester selection: a stalled request stays locked so the payload seen
  // by the adapter never changes under it; otherwise a lone requester wins,
  // and round-robin priority settles contention.
  always_comb begin
    sel = prio_q;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (req_valid_i == 2'b01) begin
      sel = 1'b0;
    end else if (req_valid_i == 2'b10) begin
      sel = 1'b1;
    end
  end

  // Request channel and response routing. The rst_n term keeps every valid
  // and ready low while reset is held. A pop at full does not free its slot
  // until the next cycle, so can_issue only looks at the registered count.
  always_comb begin
    can_issue     = rst_n && !kill_i && (cnt_q < CNT_MAX);
    trans_valid_o = can_issue && req_valid_i[sel];
    trans_o       = req_i[sel];
    req_ready_o   = 2'b00;
    req_ready_o[sel] = can_issue && trans_ready_i;

    push  = trans_valid_o && trans_ready_i;
    stall = trans_valid_o && !trans_ready_i && !kill_i;
    pop   = rst_n && resp_valid_i && (cnt_q != '0);

    head_id      = fifo_id_q[rptr_q];
    head_discard = fifo_discard_q[rptr_q];

    // A kill in the same cycle as a pop discards that response directly,
    // because the registered discard mark would only land after the pop.
    resp_valid_o = 2'b00;
    if (pop && !head_discard && !kill_i) begin
      resp_valid_o[head_id] = 1'b1;
    end

    resp_o = resp_i;
    idle_o = (cnt_q == '0);
  end

  // Outstanding counter and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
    end
  end

  // ID FIFO storage. A kill marks every entry as discard. Free slots get
  // marked too, which is harmless: a push always rewrites the discard bit,
  // and a push never happens in a kill cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_id_q[i]      <= 1'b0;
        fifo_discard_q[i] <= 1'b0;
      end
    end else begin
      if (kill_i) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          fifo_discard_q[i] <= 1'b1;
        end
      end
      if (push) begin
        fifo_id_q[wptr_q]      <= sel;
        fifo_discard_q[wptr_q] <= 1'b0;
      end
    end
  end

  // Round-robin priority and stall lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else if (kill_i) begin
      lock_q <= 1'b0;
    end else if (push) begin
      prio_q <= ~sel;
      lock_q <= 1'b0;
    end else if (stall) begin
      lock_q    <= 1'b1;
      lock_id_q <= sel;
    end
  end

`ifndef SYNTHESIS
  // A waiting requester must hold valid and payload until its handshake,
  // unless a kill intervenes.
  for (genvar k = 0; k < 2; k++) begin : g_hold_chk
    assert property (@(posedge clk) disable iff (!rst_n)
      (rst_n && req_valid_i[k] && !req_ready_o[k] && !kill_i) |=>
        (kill_i || (req_valid_i[k] && $stable(req_i[k]))));
  end

  assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_MAX);
`endif

endmodule

// File: tb/tb_cv32e40s_instr_obi_arbiter.sv
// Testbench for cv32e40s_instr_obi_arbiter.
// Drives directed scenarios and randomized traffic. Every cycle's outputs are
// compared against a queue-based reference model of the arbiter.

module tb_cv32e40s_instr_obi_arbiter;
  import cv32e40s_instr_obi_arbiter_pkg::*;

  localparam int MAXO = 2;

  typedef struct {
    int id;
    bit disc;
  } entry_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          reqValid = 2'b00;
  logic [1:0]          reqReady;
  obi_inst_req_t [1:0] reqIn = '0;
  logic [1:0]          respValidOut;
  obi_inst_resp_t      respOut;
  logic                transValid;
  logic                transReady = 1'b0;
  obi_inst_req_t       transOut;
  logic                respValidIn = 1'b0;
  obi_inst_resp_t      respIn = '0;
  logic                kill = 1'b0;
  logic                idle;

  int checks = 0;
  int errors = 0;

  // Reference model state: the in-flight queue, round-robin preference and
  // the requester currently pinned by a stalled request.
  entry_t mq[$];
  int     mPrio = 0;
  bit     mLock = 0;
  int     mLockId = 0;

  bit [1:0] lastHs = 2'b00;
  bit       lastFree = 1'b1;

  cv32e40s_instr_obi_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (reqValid),
    .req_ready_o   (reqReady),
    .req_i         (reqIn),
    .resp_valid_o  (respValidOut),
    .resp_o        (respOut),
    .trans_valid_o (transValid),
    .trans_ready_i (transReady),
    .trans_o       (transOut),
    .resp_valid_i  (respValidIn),
    .resp_i        (respIn),
    .kill_i        (kill),
    .idle_o        (idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic obi_inst_req_t randReq();
    obi_inst_req_t r;
    r.addr    = $urandom;
    r.memtype = 2'($urandom);
    r.prot    = 3'($urandom);
    r.dbg     = 1'($urandom);
    return r;
  endfunction

  task automatic applyStimulus(input logic [1:0] v, input obi_inst_req_t r0, input obi_inst_req_t r1,
                               input logic tready, input logic rv, input logic k);
    reqValid    = v;
    reqIn[0]    = r0;
    reqIn[1]    = r1;
    transReady  = tready;
    respValidIn = rv;
    kill        = k;
    respIn      = {$urandom, 2'($urandom)};
  endtask

  // One clock cycle: compare combinational outputs against the model in the
  // low phase, then advance the model on the rising edge.
  task automatic runCycle();
    int       sel;
    bit       canIssue;
    bit       expTv;
    bit       doPop;
    bit [1:0] expReady;
    bit [1:0] expResp;
    #1;
    canIssue = !kill && (mq.size() < MAXO);
    if (mLock)                   sel = mLockId;
    else if (reqValid == 2'b01)  sel = 0;
    else if (reqValid == 2'b10)  sel = 1;
    else                         sel = mPrio;
    expTv    = canIssue && reqValid[sel];
    expReady = (canIssue && transReady) ? ((sel == 0) ? 2'b01 : 2'b10) : 2'b00;
    doPop    = respValidIn && (mq.size() > 0);
    expResp  = 2'b00;
    if (doPop && !mq[0].disc && !kill) expResp = (mq[0].id == 0) ? 2'b01 : 2'b10;

    checkOutput("trans_valid", 64'(transValid), 64'(expTv));
    if (reqValid != 2'b00) checkOutput("req_ready", 64'(reqReady), 64'(expReady));
    if (expTv) checkOutput("trans_payload", 64'(transOut), 64'(reqIn[sel]));
    checkOutput("resp_valid", 64'(respValidOut), 64'(expResp));
    checkOutput("resp_payload", 64'(respOut), 64'(respIn));
    checkOutput("idle", 64'(idle), 64'(mq.size() == 0));

    lastHs   = reqValid & expReady;
    lastFree = kill;

    @(posedge clk);
    if (doPop) void'(mq.pop_front());
    if (kill) begin
      foreach (mq[i]) mq[i].disc = 1'b1;
      mLock = 0;
    end
    if (expTv && transReady) begin
      mq.push_back('{sel, 1'b0});
      mPrio = 1 - sel;
      mLock = 0;
    end else if (expTv) begin
      mLock   = 1;
      mLockId = sel;
    end
    @(negedge clk);
  endtask

  // Random traffic generator honouring the hold-until-handshake rule.
  task automatic genCycles(input int n, input int pv, input int pr, input int prs, input int pk);
    for (int c = 0; c < n; c++) begin
      logic [1:0]          v;
      obi_inst_req_t [1:0] r;
      v = reqValid;
      r = reqIn;
      for (int k = 0; k < 2; k++) begin
        if (!v[k] || lastHs[k] || lastFree) begin
          v[k] = ($urandom_range(99) < pv);
          r[k] = randReq();
        end
      end
      applyStimulus(v, r[0], r[1], $urandom_range(99) < pr, $urandom_range(99) < prs,
                    $urandom_range(99) < pk);
      runCycle();
    end
  endtask

  // Hold reset with busy-looking inputs and confirm everything is quiet.
  task automatic resetCheck();
    applyStimulus(2'b11, randReq(), randReq(), 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_trans_valid", 64'(transValid), 64'd0);
    checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
    checkOutput("rst_resp_valid", 64'(respValidOut), 64'd0);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    mq.delete();
    mPrio = 0;
    mLock = 0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    lastFree = 1'b1;
  endtask

  initial begin
    obi_inst_req_t a;
    @(negedge clk);
    resetCheck();

    // Single requester: accept at 0x100, response two cycles later.
    a = randReq();
    a.addr = 32'h100;
    applyStimulus(2'b01, a, randReq(), 1'b1, 1'b0, 1'b0);
    runCycle();
    applyStimulus(2'b00, randReq(), randReq(), 1'b1, 1'b0, 1'b0);
    runCycle();
    applyStimulus(2'b00, randReq(), randReq(), 1'b1, 1'b1, 1'b0);
    runCycle();
    applyStimulus(2'b00, randReq(), randReq(), 1'b1, 1'b0, 1'b0);
    runCycle();
    lastFree = 1'b1;

    // Round-robin with a response every cycle.
    genCycles(10, 100, 100, 100, 0);
    // Stall lock: ready held low, then released.
    genCycles(3, 100, 0, 0, 0);
    genCycles(3, 100, 100, 0, 0);
    // Full: no responses, then responses resume.
    genCycles(4, 100, 100, 0, 0);
    genCycles(4, 100, 100, 100, 0);
    // Kill with two in flight, then drain and a fresh request.
    genCycles(4, 100, 100, 0, 0);
    genCycles(1, 100, 100, 0, 100);
    genCycles(3, 0, 100, 100, 0);
    genCycles(6, 60, 100, 50, 0);

    // Kill plus pop with one outstanding, then a spurious response.
    genCycles(4, 0, 100, 100, 0);
    applyStimulus(2'b01, randReq(), randReq(), 1'b1, 1'b0, 1'b0);
    runCycle();
    applyStimulus(2'b00, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
    runCycle();
    applyStimulus(2'b00, randReq(), randReq(), 1'b1, 1'b1, 1'b0);
    runCycle();
    lastFree = 1'b1;

    // Random traffic, mid-operation reset, more random traffic.
    genCycles(1500, 70, 70, 50, 5);
    resetCheck();
    genCycles(400, 80, 60, 60, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
